// File: rtl/qpd_position_normalizer.sv
// rtl/qpd_position_normalizer.sv - intensity-normalized QPD positions via one shared restoring divider
module qpd_position_normalizer #(
    parameter int NUM_BITS_IN  = 32,
    parameter int FRAC_BITS    = 16,
    parameter int NUM_BITS_OUT = 32,
    parameter int MIN_DEN      = 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           valid_i,
    input  logic signed [NUM_BITS_IN-1:0]  x1_i,
    input  logic signed [NUM_BITS_IN-1:0]  x2_i,
    input  logic signed [NUM_BITS_IN-1:0]  y1_i,
    input  logic signed [NUM_BITS_IN-1:0]  y2_i,
    input  logic signed [NUM_BITS_IN-1:0]  i1_i,
    input  logic signed [NUM_BITS_IN-1:0]  i2_i,
    output logic        [NUM_BITS_OUT-1:0] x1n_o,
    output logic        [NUM_BITS_OUT-1:0] x2n_o,
    output logic        [NUM_BITS_OUT-1:0] y1n_o,
    output logic        [NUM_BITS_OUT-1:0] y2n_o,
    output logic        [3:0]              div0_o,
    output logic        [3:0]              sat_o,
    output logic                           busy_o,
    output logic                           overrun_o,
    output logic                           done_o
);

    localparam int ITER = NUM_BITS_IN + FRAC_BITS;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [ITER-1:0] POS_MAX =
        {{(ITER-NUM_BITS_OUT+1){1'b0}}, {(NUM_BITS_OUT-1){1'b1}}};
    localparam logic [ITER-1:0] NEG_MAG = POS_MAX + ITER'(1);
    localparam logic [NUM_BITS_OUT-1:0] OUT_MAX = {1'b0, {(NUM_BITS_OUT-1){1'b1}}};
    localparam logic [NUM_BITS_OUT-1:0] OUT_MIN = {1'b1, {(NUM_BITS_OUT-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, FINISH} state_t;

    state_t state, state_n;

    logic        [1:0]              k;
    logic        [CW-1:0]           cnt;
    logic signed [NUM_BITS_IN-1:0]  num_sh [4];
    logic signed [NUM_BITS_IN-1:0]  i1_sh, i2_sh;
    logic        [NUM_BITS_IN-1:0]  rem;
    logic        [ITER-1:0]         quot;
    logic        [NUM_BITS_IN-1:0]  den_mag;
    logic                           neg_r, num_neg_r, num_zero_r, div0_r;
    logic        [NUM_BITS_OUT-1:0] res_sh [3];
    logic        [2:0]              div0_sh, sat_sh;

    logic signed [NUM_BITS_IN-1:0]  num_sel, den_sel;
    logic        [NUM_BITS_IN-1:0]  num_abs, den_abs;
    logic        [NUM_BITS_IN:0]    rem_shift;
    logic                           take_sub;
    logic        [NUM_BITS_OUT-1:0] res_val;
    logic                           res_div0, res_sat;

    // Quotient k pairs x1,x2,y1,y2 with i1,i2,i1,i2
    assign num_sel = num_sh[k];
    assign den_sel = k[0] ? i2_sh : i1_sh;
    assign num_abs = num_sel[NUM_BITS_IN-1] ? -num_sel : num_sel;
    assign den_abs = den_sel[NUM_BITS_IN-1] ? -den_sel : den_sel;

    assign rem_shift = {rem, quot[ITER-1]};
    assign take_sub  = rem_shift >= {1'b0, den_mag};

    always_comb begin
        res_val  = '0;
        res_div0 = 1'b0;
        res_sat  = 1'b0;
        if (div0_r) begin
            res_div0 = 1'b1;
            if (num_zero_r)     res_val = '0;
            else if (num_neg_r) res_val = OUT_MIN;
            else                res_val = OUT_MAX;
        end else if (neg_r) begin
            if (quot > NEG_MAG) begin
                res_val = OUT_MIN;
                res_sat = 1'b1;
            end else begin
                res_val = NUM_BITS_OUT'(-quot);
            end
        end else if (quot > POS_MAX) begin
            res_val = OUT_MAX;
            res_sat = 1'b1;
        end else begin
            res_val = quot[NUM_BITS_OUT-1:0];
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (valid_i) state_n = LOAD;
            LOAD:    state_n = DIV;
            DIV:     if (cnt == CW'(ITER - 1)) state_n = STORE;
            STORE:   state_n = (k == 2'd3) ? FINISH : LOAD;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_n;
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            k          <= '0;
            cnt        <= '0;
            for (int i = 0; i < 4; i++) num_sh[i] <= '0;
            i1_sh      <= '0;
            i2_sh      <= '0;
            rem        <= '0;
            quot       <= '0;
            den_mag    <= '0;
            neg_r      <= 1'b0;
            num_neg_r  <= 1'b0;
            num_zero_r <= 1'b0;
            div0_r     <= 1'b0;
            for (int i = 0; i < 3; i++) res_sh[i] <= '0;
            div0_sh    <= '0;
            sat_sh     <= '0;
            x1n_o      <= '0;
            x2n_o      <= '0;
            y1n_o      <= '0;
            y2n_o      <= '0;
            div0_o     <= '0;
            sat_o      <= '0;
            overrun_o  <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (valid_i && state != IDLE) overrun_o <= 1'b1;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        num_sh[0] <= x1_i;
                        num_sh[1] <= x2_i;
                        num_sh[2] <= y1_i;
                        num_sh[3] <= y2_i;
                        i1_sh     <= i1_i;
                        i2_sh     <= i2_i;
                        k         <= '0;
                    end
                end
                LOAD: begin
                    rem        <= '0;
                    quot       <= {num_abs, {FRAC_BITS{1'b0}}};
                    den_mag    <= den_abs;
                    neg_r      <= num_sel[NUM_BITS_IN-1] ^ den_sel[NUM_BITS_IN-1];
                    num_neg_r  <= num_sel[NUM_BITS_IN-1];
                    num_zero_r <= (num_sel == '0);
                    div0_r     <= (den_abs < NUM_BITS_IN'(MIN_DEN));
                    cnt        <= '0;
                end
                DIV: begin
                    rem  <= take_sub ? (rem_shift[NUM_BITS_IN-1:0] - den_mag)
                                     : rem_shift[NUM_BITS_IN-1:0];
                    quot <= {quot[ITER-2:0], take_sub};
                    cnt  <= cnt + CW'(1);
                end
                STORE: begin
                    if (k != 2'd3) begin
                        res_sh[k]  <= res_val;
                        div0_sh[k] <= res_div0;
                        sat_sh[k]  <= res_sat;
                        k          <= k + 2'd1;
                    end else begin
                        // Last quotient goes straight out so all outputs are valid while done_o is high
                        x1n_o  <= res_sh[0];
                        x2n_o  <= res_sh[1];
                        y1n_o  <= res_sh[2];
                        y2n_o  <= res_val;
                        div0_o <= {res_div0, div0_sh};
                        sat_o  <= {res_sat, sat_sh};
                        done_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qpd_position_normalizer.sv
// tb/tb_qpd_position_normalizer.sv - self-checking bench for qpd_position_normalizer
module tb_qpd_position_normalizer;

    localparam longint OMAX = 64'sd2147483647;
    localparam longint OMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic reset_i, valid_i;
    logic signed [31:0] x1_i, x2_i, y1_i, y2_i, i1_i, i2_i;
    logic [31:0] x1n_o, x2n_o, y1n_o, y2n_o;
    logic [3:0]  div0_o, sat_o;
    logic        busy_o, overrun_o, done_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q [4];
    logic [3:0]  exp_d0, exp_sat;

    always #5 clk = ~clk;

    qpd_position_normalizer dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i),
        .x1_i(x1_i), .x2_i(x2_i), .y1_i(y1_i), .y2_i(y2_i), .i1_i(i1_i), .i2_i(i2_i),
        .x1n_o(x1n_o), .x2n_o(x2n_o), .y1n_o(y1n_o), .y2n_o(y2n_o),
        .div0_o(div0_o), .sat_o(sat_o), .busy_o(busy_o),
        .overrun_o(overrun_o), .done_o(done_o)
    );

    function automatic void model(input longint num, input longint den,
                                  output logic [31:0] q, output logic d0, output logic st);
        longint an, ad, r;
        an = (num < 0) ? -num : num;
        ad = (den < 0) ? -den : den;
        d0 = 1'b0;
        st = 1'b0;
        if (ad < 1) begin
            d0 = 1'b1;
            r  = (num > 0) ? OMAX : (num < 0) ? OMIN : 0;
        end else begin
            r = (an * 65536) / ad;
            if ((num < 0) != (den < 0)) r = -r;
            if (r > OMAX) begin r = OMAX; st = 1'b1; end
            else if (r < OMIN) begin r = OMIN; st = 1'b1; end
        end
        q = r[31:0];
    endfunction

    task automatic set_inputs(input logic signed [31:0] a, b, c, d, e, f);
        logic d0, st;
        x1_i = a; x2_i = b; y1_i = c; y2_i = d; i1_i = e; i2_i = f;
        model(a, e, exp_q[0], d0, st); exp_d0[0] = d0; exp_sat[0] = st;
        model(b, f, exp_q[1], d0, st); exp_d0[1] = d0; exp_sat[1] = st;
        model(c, e, exp_q[2], d0, st); exp_d0[2] = d0; exp_sat[2] = st;
        model(d, f, exp_q[3], d0, st); exp_d0[3] = d0; exp_sat[3] = st;
    endtask

    // Strobes valid for one cycle; lat is the cycle index at which done_o is seen, -1 on timeout
    task automatic launch(output int lat);
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1;
        while (done_o !== 1'b1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done_o !== 1'b1) lat = -1;
    endtask

    function automatic logic signed [31:0] rnd();
        logic signed [31:0] v;
        v = $urandom;
        v = v >>> $urandom_range(0, 31);
        if ($urandom_range(0, 9) == 0) v = '0;
        return v;
    endfunction

    task automatic test_reset();
        reset_i = 1'b1; valid_i = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({x1n_o, x2n_o, y1n_o, y2n_o} !== 128'd0 || div0_o !== 4'd0 || sat_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h %h %h %h d0=%b sat=%b want all 0",
                     x1n_o, x2n_o, y1n_o, y2n_o, div0_o, sat_o);
        end
        checks++;
        if ({busy_o, overrun_o, done_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status got busy=%b ovr=%b done=%b want 000", busy_o, overrun_o, done_o);
        end
        reset_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic signed [31:0] tbl [6][6];
        int lat;
        tbl = '{
            '{32'sd1000, -32'sd1000, 32'sd0, 32'sd2000, 32'sd4000, 32'sd4000},
            '{32'sd7, 32'sd1, 32'sd1, 32'sd1, -32'sd3, 32'sd5},
            '{32'sd1048576, 32'sd1, 32'sd1, 32'sd1, 32'sd1, 32'sd1},
            '{32'sh80000000, 32'sd1, 32'sd1, 32'sd1, 32'sd1, 32'sd1},
            '{32'sd0, 32'sd5, 32'sd0, -32'sd5, 32'sd0, 32'sd0},
            '{32'sh80000000, 32'sh7FFFFFFF, 32'sh80000000, 32'sd0, 32'sh80000000, -32'sd1}
        };
        for (int v = 0; v < 6; v++) begin
            set_inputs(tbl[v][0], tbl[v][1], tbl[v][2], tbl[v][3], tbl[v][4], tbl[v][5]);
            checks++;
            if (busy_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_busy vec=%0d got %b want 0", v, busy_o);
            end
            launch(lat);
            checks++;
            if (lat !== 201) begin
                errors++;
                $display("FAIL latency vec=%0d got %0d want 201", v, lat);
            end
            checks++;
            if ({x1n_o, x2n_o, y1n_o, y2n_o} !== {exp_q[0], exp_q[1], exp_q[2], exp_q[3]}) begin
                errors++;
                $display("FAIL directed_q vec=%0d got %h %h %h %h want %h %h %h %h", v,
                         x1n_o, x2n_o, y1n_o, y2n_o, exp_q[0], exp_q[1], exp_q[2], exp_q[3]);
            end
            checks++;
            if (div0_o !== exp_d0 || sat_o !== exp_sat) begin
                errors++;
                $display("FAIL directed_flags vec=%0d got d0=%b sat=%b want d0=%b sat=%b",
                         v, div0_o, sat_o, exp_d0, exp_sat);
            end
            if (v == 0) begin
                checks++;
                if (x1n_o !== 32'h00004000 || x2n_o !== 32'hFFFFC000 || y1n_o !== 32'h0 || y2n_o !== 32'h00008000) begin
                    errors++;
                    $display("FAIL basic_const got %h %h %h %h want 00004000 ffffc000 0 00008000",
                             x1n_o, x2n_o, y1n_o, y2n_o);
                end
            end
            if (v == 1) begin
                checks++;
                if (x1n_o !== 32'hFFFDAAAB) begin
                    errors++;
                    $display("FAIL trunc_const got %h want fffdaaab", x1n_o);
                end
            end
            if (v == 4) begin
                checks++;
                if (div0_o !== 4'b1111 || sat_o !== 4'b0000) begin
                    errors++;
                    $display("FAIL div0_const got d0=%b sat=%b want 1111 0000", div0_o, sat_o);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (done_o !== 1'b0) begin
                errors++;
                $display("FAIL done_width vec=%0d got %b want 0", v, done_o);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        for (int n = 0; n < 25; n++) begin
            set_inputs(rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
            launch(lat);
            checks++;
            if (lat !== 201) begin
                errors++;
                $display("FAIL rand_latency n=%0d got %0d want 201", n, lat);
            end
            checks++;
            if ({x1n_o, x2n_o, y1n_o, y2n_o} !== {exp_q[0], exp_q[1], exp_q[2], exp_q[3]} ||
                div0_o !== exp_d0 || sat_o !== exp_sat) begin
                errors++;
                $display("FAIL rand_result n=%0d in %h %h %h %h %h %h got %h %h %h %h %b %b want %h %h %h %h %b %b",
                         n, x1_i, x2_i, y1_i, y2_i, i1_i, i2_i, x1n_o, x2n_o, y1n_o, y2n_o, div0_o, sat_o,
                         exp_q[0], exp_q[1], exp_q[2], exp_q[3], exp_d0, exp_sat);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_overrun();
        int cyc, lat;
        set_inputs(rnd(), rnd(), rnd(), rnd(), 32'sd12345, -32'sd777);
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        cyc = 1;
        while (done_o !== 1'b1 && cyc < 400) begin
            if (cyc == 50) begin
                valid_i = 1'b1;
                x1_i = 32'sh12345678; i1_i = 32'sd3;
            end else begin
                valid_i = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        valid_i = 1'b0;
        checks++;
        if (cyc !== 201 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL ovr_latency got %0d want 201", cyc);
        end
        checks++;
        if ({x1n_o, x2n_o, y1n_o, y2n_o} !== {exp_q[0], exp_q[1], exp_q[2], exp_q[3]} ||
            div0_o !== exp_d0 || sat_o !== exp_sat) begin
            errors++;
            $display("FAIL ovr_result got %h %h %h %h want %h %h %h %h",
                     x1n_o, x2n_o, y1n_o, y2n_o, exp_q[0], exp_q[1], exp_q[2], exp_q[3]);
        end
        checks++;
        if (overrun_o !== 1'b1) begin
            errors++;
            $display("FAIL ovr_flag got %b want 1", overrun_o);
        end
        @(posedge clk); #1;
        set_inputs(32'sd300, -32'sd9, 32'sd65535, 32'sd42, 32'sd600, 32'sd7);
        launch(lat);
        checks++;
        if (lat !== 201) begin
            errors++;
            $display("FAIL ovr_next_latency got %0d want 201", lat);
        end
        checks++;
        if ({x1n_o, x2n_o, y1n_o, y2n_o} !== {exp_q[0], exp_q[1], exp_q[2], exp_q[3]}) begin
            errors++;
            $display("FAIL ovr_next_result got %h %h %h %h want %h %h %h %h",
                     x1n_o, x2n_o, y1n_o, y2n_o, exp_q[0], exp_q[1], exp_q[2], exp_q[3]);
        end
        checks++;
        if (overrun_o !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky got %b want 1", overrun_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int cyc, lat, seen;
        set_inputs(rnd(), rnd(), rnd(), rnd(), 32'sd1000, 32'sd2000);
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (cyc = 1; cyc < 100; cyc++) begin
            @(posedge clk); #1;
        end
        reset_i = 1'b1;
        #1;
        checks++;
        if ({x1n_o, x2n_o, y1n_o, y2n_o} !== 128'd0 || div0_o !== 4'd0 || sat_o !== 4'd0 ||
            busy_o !== 1'b0 || overrun_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs got %h %h %h %h d0=%b sat=%b busy=%b ovr=%b done=%b want all 0",
                     x1n_o, x2n_o, y1n_o, y2n_o, div0_o, sat_o, busy_o, overrun_o, done_o);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 250; i++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d pulses want 0", seen);
        end
        set_inputs(-32'sd5000, 32'sd1, 32'sd2500, -32'sd1, 32'sd10000, 32'sd3);
        launch(lat);
        checks++;
        if (lat !== 201) begin
            errors++;
            $display("FAIL post_reset_latency got %0d want 201", lat);
        end
        checks++;
        if ({x1n_o, x2n_o, y1n_o, y2n_o} !== {exp_q[0], exp_q[1], exp_q[2], exp_q[3]} || overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_result got %h %h %h %h ovr=%b want %h %h %h %h ovr=0",
                     x1n_o, x2n_o, y1n_o, y2n_o, overrun_o, exp_q[0], exp_q[1], exp_q[2], exp_q[3]);
        end
        // A strobe landing in the FINISH cycle is an overrun, not a new start
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL finish_busy got %b want 1", busy_o);
        end
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        checks++;
        if (overrun_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL finish_overrun got ovr=%b busy=%b want ovr=1 busy=0", overrun_o, busy_o);
        end
        seen = 0;
        for (int i = 0; i < 250; i++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL finish_ignored got %0d pulses want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_overrun();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qpd_position_normalizer.md
Name: qpd_position_normalizer

Overview:
- Downstream of the QPD demodulator.
- Captures the six low-passed demodulated quadratures (x1, x2, y1, y2, i1, i2) on the demodulator's done strobe.
- Produces intensity-normalized positions x1/i1, x2/i2, y1/i1, y2/i2 as signed fixed-point values.
- One shared iterative restoring divider is time-multiplexed over the four quotients. The result is independent of laser power and ready for the telemetry/feedback path.

Parameters:
- NUM_BITS_IN, 32, width of signed input quadratures.
- FRAC_BITS, 16, fractional bits of each output quotient.
- NUM_BITS_OUT, 32, width of each signed output (Q(NUM_BITS_OUT-FRAC_BITS-1).FRAC_BITS).
- MIN_DEN, 1, smallest denominator magnitude treated as valid. |den| < MIN_DEN counts as divide-by-zero.

Ports:
- clk_i, input, 1, system clock.
- reset_i, input, 1, asynchronous active-high reset.
- valid_i, input, 1, one-cycle strobe (connect to the demodulator's done_o); all data inputs are sampled when it is high.
- x1_i, x2_i, y1_i, y2_i, input, NUM_BITS_IN each, signed demodulated position quadratures.
- i1_i, i2_i, input, NUM_BITS_IN each, signed demodulated intensity quadratures.
- x1n_o, x2n_o, y1n_o, y2n_o, output, NUM_BITS_OUT each, signed normalized positions.
- div0_o, output, 4, per-quotient divide-by-zero flag for the last result set (bit0 x1n, bit1 x2n, bit2 y1n, bit3 y2n).
- sat_o, output, 4, per-quotient saturation flag for the last result set (same bit order).
- busy_o, output, 1, high while a computation is in progress.
- overrun_o, output, 1, sticky: a valid_i strobe arrived while busy.
- done_o, output, 1, one-cycle strobe when all outputs update.

Behaviour:
- Reset (async, reset_i=1): all outputs 0, FSM in IDLE, shadow and divider registers cleared. Reset mid-computation aborts it; done_o does not fire for the aborted set.
- FSM states: IDLE, LOAD, DIV, STORE, FINISH. Quotient index k runs 0..3 with pairs (x1,i1), (x2,i2), (y1,i1), (y2,i2).
- IDLE: on valid_i=1, register all six inputs, set k=0, go to LOAD, assert busy_o from the next cycle.
- LOAD (1 cycle):
  - Form |num| and |den| as NUM_BITS_IN-bit unsigned values; |-2^(N-1)| = 2^(N-1) with no wrap.
  - Dividend = |num| << FRAC_BITS. Record sign = sign(num) XOR sign(den).
- DIV (ITER = NUM_BITS_IN+FRAC_BITS cycles): one restoring-division step per cycle, MSB first, producing an unsigned ITER-bit quotient truncated toward zero.
- STORE (1 cycle): apply sign, saturate, write the shadow result and the div0/sat bit k. If k<3, k++ and go to LOAD; otherwise go to FINISH.
- FINISH (1 cycle): copy the shadow results and flags to the outputs simultaneously, pulse done_o, clear busy_o, return to IDLE. Outputs hold their values between done_o pulses.
- Latency: valid_i at cycle 0 gives done_o at cycle 1+4*(ITER+2). Defaults: ITER=48, done_o at cycle 201. The next valid_i is accepted in the cycle after done_o, i.e. as soon as the FSM is back in IDLE.
- Saturation:
  - Positive result > 2^(NUM_BITS_OUT-1)-1 is clamped to max.
  - Negative result magnitude > 2^(NUM_BITS_OUT-1) is clamped to min (-2^(NUM_BITS_OUT-1)).
  - Either case sets sat bit k.
- Divide-by-zero (|den| < MIN_DEN): skip the DIV iterations' effect.
  - num>0 gives max; num<0 gives min; num=0 gives 0.
  - Sets div0 bit k; sat bit k stays 0.
  - Cycle timing is unchanged (DIV still runs ITER cycles) so latency is constant.
- Overrun: valid_i while busy_o=1 is ignored and overrun_o is set; it stays set until reset. The in-flight computation is unaffected.
- valid_i in the same cycle as FINISH counts as overrun; busy_o is still 1 in that cycle.

Test Plan:
- x1=1000, i1=4000, x2=-1000, i2=4000, y1=0, y2=2000 -> at cycle 201: x1n=0x00004000, x2n=0xFFFFC000, y1n=0, y2n=0x00008000; div0=0, sat=0, done_o high exactly one cycle.
- x1=7, i1=-3 (others benign) -> x1n=-(7*65536/3) truncated = -152917 (0xFFFDAAAB); sign and truncation toward zero checked.
- x1=2^20, i1=1 -> x1n=0x7FFFFFFF, sat_o[0]=1. x1=-2^31, i1=1 -> x1n=0x80000000, sat_o[0]=1.
- i2=0, x2=5, y2=-5, y1=0, i1=0 -> x2n=0x7FFFFFFF, y2n=0x80000000, y1n=0, x1n=0; div0_o=4'b1111; latency still 201.
- Second valid_i at cycle 50 -> ignored, overrun_o=1 and sticky; first result set is correct at 201. A fresh valid_i at cycle 202 is accepted and completes at cycle 403.
- reset_i asserted at cycle 100 -> all outputs 0 immediately, no done_o. A new valid_i after release completes normally 201 cycles later.
